// File: rtl/seg_mux_pkg.sv
// Shared types and constants for the 7-segment digit scheduler.
// Combinational constants only; no timing or flow control.
package seg_mux_pkg;

  typedef enum logic [1:0] {
    SHOW_HI  = 2'd0,
    BLANK_HI = 2'd1,
    SHOW_LO  = 2'd2,
    BLANK_LO = 2'd3
  } seg_state_t;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Active-high {G,F,E,D,C,B,A} glyphs for 0-9, A, b, C, d, E, F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Nibble to 7-segment pattern with output polarity applied.
// Purely combinational, zero latency; no flow control.
module seg_hex_decode
  import seg_mux_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = (ACTIVE_LOW != 0) ? ~HEX_SEG[nibble] : HEX_SEG[nibble];

endmodule

// File: rtl/seg_mux_scheduler.sv
// Upper/lower hex digit time-mux; outputs registered one cycle behind state. i_Load is never
// refused, and a loaded byte shows from the next frame boundary. SEG_MUX_BLANK_EN adds blank slots.
module seg_mux_scheduler
  import seg_mux_pkg::*;
#(
  parameter int CLKS_PER_DIGIT = 6000,
  parameter int BLANK_CLKS     = 120,
  parameter int ACTIVE_LOW     = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Load,
  input  logic [7:0] i_Byte,
  output logic [6:0] o_Segments,
  output logic       o_Segment_Digit,
  output logic       o_Frame_Done,
  output logic       o_Pending
);

  localparam int CNT_W = $clog2(max_int(CLKS_PER_DIGIT, BLANK_CLKS));
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(CLKS_PER_DIGIT - 1);
`ifdef SEG_MUX_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CLKS - 1);
`endif
  localparam logic [6:0] SEG_OFF_POL = (ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;

  seg_state_t       state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [7:0]       display, shadow;
  logic             pending;
  logic             boundary, nxt_boundary;
  logic [3:0]       nibble;
  logic [6:0]       dec_seg, seg_nxt;
  logic             digit_nxt;

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + CNT_W'(1);
    case (state)
`ifdef SEG_MUX_BLANK_EN
      SHOW_HI:  if (cnt == SHOW_LAST)  begin nxt_state = BLANK_HI; nxt_cnt = '0; end
      BLANK_HI: if (cnt == BLANK_LAST) begin nxt_state = SHOW_LO;  nxt_cnt = '0; end
      SHOW_LO:  if (cnt == SHOW_LAST)  begin nxt_state = BLANK_LO; nxt_cnt = '0; end
      BLANK_LO: if (cnt == BLANK_LAST) begin nxt_state = SHOW_HI;  nxt_cnt = '0; end
`else
      SHOW_HI:  if (cnt == SHOW_LAST)  begin nxt_state = SHOW_LO;  nxt_cnt = '0; end
      SHOW_LO:  if (cnt == SHOW_LAST)  begin nxt_state = SHOW_HI;  nxt_cnt = '0; end
`endif
      default: begin nxt_state = SHOW_HI; nxt_cnt = '0; end
    endcase
  end

  // Frame-done is registered from the next state so it is high during the boundary cycle itself
`ifdef SEG_MUX_BLANK_EN
  assign boundary     = (state == BLANK_LO) && (cnt == BLANK_LAST);
  assign nxt_boundary = (nxt_state == BLANK_LO) && (nxt_cnt == BLANK_LAST);
  assign digit_nxt    = (state == SHOW_LO) || (state == BLANK_HI);
`else
  assign boundary     = (state == SHOW_LO) && (cnt == SHOW_LAST);
  assign nxt_boundary = (nxt_state == SHOW_LO) && (nxt_cnt == SHOW_LAST);
  assign digit_nxt    = (state == SHOW_LO);
`endif

  assign nibble = (state == SHOW_HI) ? display[7:4] : display[3:0];

  seg_hex_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    seg_nxt = dec_seg;
`ifdef SEG_MUX_BLANK_EN
    if ((state == BLANK_HI) || (state == BLANK_LO)) seg_nxt = SEG_OFF_POL;
`endif
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state           <= SHOW_HI;
      cnt             <= '0;
      display         <= 8'h00;
      shadow          <= 8'h00;
      pending         <= 1'b0;
      o_Segments      <= SEG_OFF_POL;
      o_Segment_Digit <= 1'b0;
      o_Frame_Done    <= 1'b0;
    end else begin
      state           <= nxt_state;
      cnt             <= nxt_cnt;
      o_Segments      <= seg_nxt;
      o_Segment_Digit <= digit_nxt;
      o_Frame_Done    <= nxt_boundary;
      if (i_Load) shadow <= i_Byte;
      if (boundary) begin
        pending <= 1'b0;
        if (i_Load)       display <= i_Byte;
        else if (pending) display <= shadow;
      end else if (i_Load) begin
        pending <= 1'b1;
      end
    end
  end

  assign o_Pending = pending;

endmodule

// File: tb/tb_seg_mux_scheduler.sv
// Bench for seg_mux_scheduler: time-indexed reference model plus directed and random stimulus.
module tb_seg_mux_scheduler;

  localparam int C  = 4;
  localparam int BK = 2;
`ifdef SEG_MUX_BLANK_EN
  localparam int BL = BK;
`else
  localparam int BL = 0;
`endif
  localparam int F = 2 * (C + BL);

  // Active-low glyphs 0..F
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct {
    logic [7:0] b;
    logic [6:0] hi;
    logic [6:0] lo;
  } vec_t;

  logic       i_Clk, i_Rst, i_Load;
  logic [7:0] i_Byte;
  logic [6:0] o_Segments;
  logic       o_Segment_Digit, o_Frame_Done, o_Pending;

  seg_mux_scheduler #(.CLKS_PER_DIGIT(C), .BLANK_CLKS(BK), .ACTIVE_LOW(1)) dut (
    .i_Clk           (i_Clk),
    .i_Rst           (i_Rst),
    .i_Load          (i_Load),
    .i_Byte          (i_Byte),
    .o_Segments      (o_Segments),
    .o_Segment_Digit (o_Segment_Digit),
    .o_Frame_Done    (o_Frame_Done),
    .o_Pending       (o_Pending)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  int n_chk, n_pass;

  // Model: t counts cycles since reset release; frame position is t mod F
  int         t;
  logic [7:0] m_disp, m_shad;
  logic       m_pend;
  logic [6:0] e_seg;
  logic       e_dig, e_fd;

  logic       watch_en;
  logic [6:0] watch_a, watch_b;
  int         bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int phase(input int tt);
    int p;
    p = tt % F;
    if (p < C) return 0;
    if (p < C + BL) return 1;
    if (p < 2 * C + BL) return 2;
    return 3;
  endfunction

  task automatic cyc(input logic rst, input logic ld, input logic [7:0] b);
    int ph;
    @(negedge i_Clk);
    chk("seg", o_Segments, e_seg);
    chk("digit", o_Segment_Digit, e_dig);
    chk("frame_done", o_Frame_Done, e_fd);
    chk("pending", o_Pending, m_pend);
    if (watch_en && (o_Segments === watch_a || o_Segments === watch_b)) bad++;
    i_Rst  = rst;
    i_Load = ld;
    i_Byte = b;
    if (rst) begin
      t = 0; m_disp = 8'h00; m_shad = 8'h00; m_pend = 1'b0;
      e_seg = 7'h7F; e_dig = 1'b0; e_fd = 1'b0;
    end else begin
      ph    = phase(t);
      e_seg = (ph == 1 || ph == 3) ? 7'h7F : GLYPH[(ph == 0) ? m_disp[7:4] : m_disp[3:0]];
      e_dig = (ph == 1 || ph == 2);
      e_fd  = ((t + 1) % F == F - 1);
      if (ld) m_shad = b;
      if (t % F == F - 1) begin
        if (ld) m_disp = b;
        else if (m_pend) m_disp = m_shad;
        m_pend = 1'b0;
      end else if (ld) begin
        m_pend = 1'b1;
      end
      t++;
    end
  endtask

  task automatic wait_boundary();
    for (int i = 0; i < 2 * F && !e_fd; i++) cyc(1'b0, 1'b0, 8'h00);
    chk("boundary_reached", e_fd, 1);
  endtask

  task automatic wait_frame_start();
    for (int i = 0; i < 2 * F && (t % F) != 0; i++) cyc(1'b0, 1'b0, 8'h00);
    chk("frame_start_reached", t % F, 0);
  endtask

  // Optionally load on the boundary, then check the next frame's digits
  task automatic show_frame(input string name, input logic ld, input logic [7:0] b,
                            input logic [6:0] hi, input logic [6:0] lo);
    wait_boundary();
    cyc(1'b0, ld, b);
    cyc(1'b0, 1'b0, 8'h00);
    chk({name, "_pend"}, o_Pending, 0);
    cyc(1'b0, 1'b0, 8'h00);
    chk({name, "_hi"}, o_Segments, hi);
    chk({name, "_hi_dig"}, o_Segment_Digit, 0);
    repeat (C + BL) cyc(1'b0, 1'b0, 8'h00);
    chk({name, "_lo"}, o_Segments, lo);
    chk({name, "_lo_dig"}, o_Segment_Digit, 1);
  endtask

  initial begin
    vec_t vecs [9];
    int   last, pulses;
    vecs[0] = '{8'h5F, 7'h12, 7'h0E};
    vecs[1] = '{8'h01, 7'h40, 7'h79};
    vecs[2] = '{8'h23, 7'h24, 7'h30};
    vecs[3] = '{8'h45, 7'h19, 7'h12};
    vecs[4] = '{8'h67, 7'h02, 7'h78};
    vecs[5] = '{8'h89, 7'h00, 7'h10};
    vecs[6] = '{8'hAB, 7'h08, 7'h03};
    vecs[7] = '{8'hCD, 7'h46, 7'h21};
    vecs[8] = '{8'hEF, 7'h06, 7'h0E};

    n_chk = 0; n_pass = 0; bad = 0;
    watch_en = 1'b0; watch_a = 7'h7F; watch_b = 7'h7F;
    t = 0; m_disp = 8'h00; m_shad = 8'h00; m_pend = 1'b0;
    e_seg = 7'h7F; e_dig = 1'b0; e_fd = 1'b0;
    i_Rst = 1'b1; i_Load = 1'b0; i_Byte = 8'h00;

    // Reset and first frame
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
    chk("rst_seg", o_Segments, 7'h7F);
    chk("rst_dig", o_Segment_Digit, 0);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    chk("first_hi", o_Segments, 7'h40);
    repeat (2 * F) cyc(1'b0, 1'b0, 8'h00);

    // Frame-done period
    last = -1; pulses = 0;
    for (int i = 0; i < 6 * F; i++) begin
      cyc(1'b0, 1'b0, 8'h00);
      if (o_Frame_Done === 1'b1) begin
        if (last >= 0) chk("fd_period", i - last, F);
        last = i;
        pulses++;
      end
    end
    chk("fd_count", pulses, 6);

    // Deferred load
    for (int i = 0; i < 2 * F && phase(t) != 0; i++) cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'h3A);
    cyc(1'b0, 1'b0, 8'h00);
    chk("defer_pend", o_Pending, 1);
    show_frame("defer", 1'b0, 8'h00, 7'h30, 7'h08);

    // Overwrite within one frame
    wait_frame_start();
    watch_en = 1'b1; watch_a = 7'h79; watch_b = 7'h24; bad = 0;
    cyc(1'b0, 1'b1, 8'h12);
    cyc(1'b0, 1'b1, 8'h34);
    show_frame("ovw", 1'b0, 8'h00, 7'h30, 7'h19);
    repeat (F) cyc(1'b0, 1'b0, 8'h00);
    watch_en = 1'b0;
    chk("ovw_no_1_2", bad, 0);

    // Coincident loads on the boundary, all glyphs
    for (int k = 0; k < 9; k++) show_frame("bypass", 1'b1, vecs[k].b, vecs[k].hi, vecs[k].lo);

    // Mid-frame reset discards a pending byte
    wait_frame_start();
    cyc(1'b0, 1'b1, 8'h77);
    for (int i = 0; i < 2 * F && phase(t) != 2; i++) cyc(1'b0, 1'b0, 8'h00);
    chk("mid_pend_before", o_Pending, 1);
    watch_en = 1'b1; watch_a = 7'h78; watch_b = 7'h78; bad = 0;
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    chk("mid_rst_pend", o_Pending, 0);
    chk("mid_rst_seg", o_Segments, 7'h7F);
    show_frame("mid_rst", 1'b0, 8'h00, 7'h40, 7'h40);
    repeat (F) cyc(1'b0, 1'b0, 8'h00);
    watch_en = 1'b0;
    chk("mid_no_7", bad, 0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      cyc(r == 0, r < 12, 8'($urandom));
    end
    cyc(1'b0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
